// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter in front of a single FIFO.
// It tracks FIFO fill level with credits and grants one requester per cycle.
//
// Ports
//   clk, reset        : single clock; synchronous active-high reset
//   req, req_data     : per-requester level request and packed payload
//                       (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   gnt               : registered one-hot grant pulse
//   fifo_cs/_wr_en    : registered FIFO write strobes
//   fifo_data_in      : registered write data; holds between writes
//   fifo_rd_en/_empty : observed consumer side, used to return credits
//   fifo_full         : FIFO full flag; suppresses grants
//   blocked           : high while eligible requests wait for credit
//   occupancy         : credit-tracked fill level
//
// Optional feature: define FIFO_WR_ARB_STATS_EN to add stat_sel/stat_count,
// a saturating 16-bit grant counter per requester read through a mux.

`ifdef FIFO_WR_ARB_STATS_EN
// Saturating grant counter for one requester.
module fifo_wr_arb_stat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule
`endif

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              fifo_cs,
  output logic                              fifo_wr_en,
  output logic [DATA_WIDTH-1:0]             fifo_data_in,
  input  logic                              fifo_rd_en,
  input  logic                              fifo_empty,
  input  logic                              fifo_full,
  output logic                              blocked,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0]        stat_sel,
  output logic [15:0]                       stat_count
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int OW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLOCKED} state_t;

  state_t                               state_q, state_d;
  logic [NUM_REQ-1:0]                   gnt_q, gnt_d;
  logic                                 cs_q, cs_d;
  logic                                 wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]                data_q, data_d;
  logic [OW-1:0]                        occ_q, occ_d;
  logic [IW-1:0]                        last_q, last_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_a;
  logic [NUM_REQ-1:0]                   elig;
  logic                                 any_elig, credit_ok, grant, rd_fire, found;
  logic [IW-1:0]                        win;

  assign req_data_a = req_data;

  // A requester shown a grant this cycle sits out this arbitration, so a
  // held level request is not granted twice for one transfer.
  assign elig      = req & ~gnt_q;
  assign any_elig  = |elig;
  assign credit_ok = occ_q < OW'(FIFO_DEPTH);
  assign grant     = any_elig && credit_ok && !fifo_full;
  assign rd_fire   = fifo_rd_en && !fifo_empty;

  // Round-robin: first eligible requester after last_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // State follows the eligibility/credit picture sampled at each edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_elig) state_d = grant ? ACTIVE : BLOCKED;
      ACTIVE:  if (!any_elig)  state_d = IDLE;
               else if (!grant) state_d = BLOCKED;
      BLOCKED: if (!any_elig)  state_d = IDLE;
               else if (grant) state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = '0;
    cs_d    = 1'b0;
    wr_en_d = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
    if (grant) begin
      gnt_d   = NUM_REQ'(1) << win;
      cs_d    = 1'b1;
      wr_en_d = 1'b1;
      data_d  = req_data_a[win];
      last_d  = win;
    end
  end

  // A grant and a read on the same edge cancel; grant implies credit_ok so
  // the increment cannot overflow, and the decrement is floored at zero.
  always_comb begin
    occ_d = occ_q;
    if (grant && !rd_fire)                           occ_d = occ_q + OW'(1);
    else if (rd_fire && !grant && occ_q != '0)       occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cs_q    <= 1'b0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      occ_q   <= '0;
      last_q  <= IW'(NUM_REQ-1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
      last_q  <= last_d;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_cs      = cs_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign occupancy    = occ_q;
  assign blocked      = (state_q == BLOCKED);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    fifo_wr_arb_stat_cnt u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (grant && win == IW'(g)),
      .count (cnt[g])
    );
  end

  // Out-of-range selects (non power-of-two NUM_REQ) read as zero.
  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (stat_sel == IW'(i)) stat_count = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a driver applies stimulus on the
// falling edge and pushes the reference model's prediction; a monitor pops
// and compares after each rising edge.
module tb_fifo_wr_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int DEPTH = 16;
  localparam int OW = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     gnt;
  logic              fifo_cs, fifo_wr_en;
  logic [DW-1:0]     fifo_data_in;
  logic              fifo_rd_en = 1'b0, fifo_empty = 1'b1, fifo_full = 1'b0;
  logic              blocked;
  logic [OW-1:0]     occupancy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [1:0]        stat_sel = '0;
  logic [15:0]       stat_count;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_cs(fifo_cs), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .blocked(blocked), .occupancy(occupancy)
`ifdef FIFO_WR_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );

  typedef struct {
    logic [NR-1:0] gnt;
    logic          wr;
    logic [DW-1:0] data;
    int            occ;
    logic          blk;
    int            stat;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;
  int wr_seen = 0;

  // Reference model state: fill level, rotation pointer, who is shown a
  // grant right now, last written word and per-requester grant totals.
  int            m_occ = 0, m_last = NR-1, m_gnt = -1;
  logic [DW-1:0] m_data = '0;
  int            m_cnt[NR];
  logic [DW-1:0] d_a[NR];
  bit            fix_data = 0;
  int            sel_v = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", n, $time, act, exp);
    end
  endtask

  task automatic step(input bit rst, input logic [NR-1:0] r, input bit rd,
                      input bit emp, input bit ful);
    exp_t e;
    bit   elig[NR];
    bit   any, can, fire;
    int   w;
    @(negedge clk);
    if (!fix_data) for (int i = 0; i < NR; i++) d_a[i] = $urandom;
    reset = rst; req = r; fifo_rd_en = rd; fifo_empty = emp; fifo_full = ful;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = d_a[i];
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel = 2'(sel_v);
`endif
    if (rst) begin
      m_occ = 0; m_last = NR-1; m_gnt = -1; m_data = '0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      e.gnt = '0; e.wr = 0; e.data = '0; e.occ = 0; e.blk = 0; e.stat = 0;
    end else begin
      any = 0;
      for (int i = 0; i < NR; i++) begin
        elig[i] = r[i] && (i != m_gnt);
        any |= elig[i];
      end
      can = any && (m_occ < DEPTH) && !ful;
      w = -1;
      for (int k = 1; k <= NR; k++)
        if (w < 0 && elig[(m_last + k) % NR]) w = (m_last + k) % NR;
      fire = rd && !emp;
      if (can && !fire) m_occ++;
      else if (fire && !can && m_occ > 0) m_occ--;
      if (can) begin
        m_last = w; m_data = d_a[w];
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end
      m_gnt = can ? w : -1;
      e.gnt = can ? NR'(1) << w : '0;
      e.wr = can; e.data = m_data; e.occ = m_occ; e.blk = any && !can;
      e.stat = m_cnt[sel_v];
    end
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (fifo_wr_en === 1'b1) wr_seen++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("fifo_cs", 32'(fifo_cs), 32'(e.wr));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wr));
        chk("fifo_data_in", fifo_data_in, e.data);
        chk("occupancy", 32'(occupancy), 32'(e.occ));
        chk("blocked", 32'(blocked), 32'(e.blk));
`ifdef FIFO_WR_ARB_STATS_EN
        chk("stat_count", 32'(stat_count), 32'(e.stat));
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; d_a[i] = '0; end
    repeat (2) step(1, '0, 0, 1, 0);

    // Single requester with a known payload
    fix_data = 1; d_a[2] = 32'hA5A5A5A5;
    step(0, 4'b0100, 0, 1, 0);
    step(0, 4'b0000, 0, 1, 0);
    fix_data = 0;
    @(posedge clk); #2;
    chk("single_data", fifo_data_in, 32'hA5A5A5A5);
    chk("single_occ", 32'(occupancy), 32'd1);

    // Fairness from reset: eight consecutive rotating grants
    step(1, '0, 0, 1, 0);
    repeat (8) step(0, 4'b1111, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // Credit exhaustion with no reads
    step(1, '0, 0, 1, 0);
    @(posedge clk); #2; wr_seen = 0;
    repeat (40) step(0, 4'b0001, 0, 1, 0);
    @(posedge clk); #2;
    chk("exhaust_writes", 32'(wr_seen), 32'd16);
    chk("exhaust_blocked", 32'(blocked), 32'd1);
    chk("exhaust_occ", 32'(occupancy), 32'd16);
    chk("exhaust_wr_en", 32'(fifo_wr_en), 32'd0);

    // Full credit: one read lets requester 1 back in
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0010, 0, 1, 0);
    step(0, 4'b0000, 0, 1, 0);
    // Read and grant on the same edge cancel
    step(0, 4'b0000, 1, 0, 0);
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0000, 0, 1, 0);

    // Reset in the middle of granting
    step(1, '0, 0, 1, 0);
    step(0, 4'b0011, 0, 1, 0);
    step(0, 4'b0011, 0, 1, 0);
    step(1, 4'b0011, 0, 1, 0);
    step(0, 4'b0011, 0, 1, 0);
    step(0, 4'b0000, 0, 1, 0);

    // Three grants to requester 1, observed through the stats port
    sel_v = 1;
    step(1, '0, 0, 1, 0);
    repeat (3) begin
      step(0, 4'b0010, 0, 1, 0);
      step(0, 4'b0000, 0, 1, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      sel_v = int'($urandom_range(0, NR-1));
      step($urandom_range(0, 199) == 0, NR'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    @(posedge clk); #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each requester payload and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of write requesters, legal range 2..8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entry count of the downstream FIFO, used for credit tracking.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester write request, level.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port gnt, output, NUM_REQ, one-hot grant pulse, registered.
REQ-009 SHALL have port fifo_cs, output, 1, FIFO chip select, registered.
REQ-010 SHALL have port fifo_wr_en, output, 1, FIFO write enable, registered.
REQ-011 SHALL have port fifo_data_in, output, DATA_WIDTH, FIFO write data, registered.
REQ-012 SHALL have port fifo_rd_en, input, 1, observed read enable of the FIFO consumer.
REQ-013 SHALL have port fifo_empty, input, 1, the FIFO empty flag.
REQ-014 SHALL have port fifo_full, input, 1, the FIFO full flag.
REQ-015 SHALL have port blocked, output, 1, high while in state BLOCKED.
REQ-016 SHALL have port occupancy, output, $clog2(FIFO_DEPTH+1), credit-tracked FIFO fill level.

Function
REQ-017 SHALL implement FSM states IDLE (no eligible req), ACTIVE (granting), BLOCKED (eligible req present, no credit or fifo_full=1).
REQ-018 SHALL define eligible(i) = req[i] && !gnt[i]; a requester granted in the current cycle is excluded from that cycle's arbitration.
REQ-019 SHALL grant when any requester is eligible, occupancy < FIFO_DEPTH and fifo_full = 0.
REQ-020 SHALL select round-robin: search starts at last_granted+1 modulo NUM_REQ; last_granted updates only on a grant.
REQ-021 SHALL, on a grant decided at edge N, drive at cycle N+1: gnt[winner]=1, fifo_cs=1, fifo_wr_en=1, fifo_data_in=req_data of winner sampled at edge N; each for exactly one cycle (latency 1).
REQ-022 SHALL sustain one grant per cycle under continuous eligible requests with available credit.
REQ-023 SHALL define rd_fire = fifo_rd_en && !fifo_empty.
REQ-024 SHALL update occupancy at each edge: +1 on grant decision only, -1 on rd_fire only, unchanged on both or neither; never wraps below 0 or above FIFO_DEPTH.
REQ-025 SHALL transition IDLE->ACTIVE or IDLE->BLOCKED when eligible reqs appear, ACTIVE/BLOCKED->IDLE when none remain, BLOCKED->ACTIVE when credit returns and fifo_full=0.
REQ-026 SHALL drive fifo_cs=0, fifo_wr_en=0 and all gnt=0 in any cycle without a grant; fifo_data_in holds its last value.

Reset
REQ-027 SHALL, on reset=1 at an edge, set gnt=0, fifo_cs=0, fifo_wr_en=0, fifo_data_in=0, occupancy=0, blocked=0, state IDLE, last_granted=NUM_REQ-1 so requester 0 has first priority.
REQ-028 SHALL, on reset asserted during ACTIVE, discard any pending grant: no fifo_wr_en in the cycle after the reset edge.

Configuration
REQ-029 SHALL, with macro FIFO_WR_ARB_STATS_EN defined, add input stat_sel ($clog2(NUM_REQ)) and output stat_count (16), where stat_count is the saturating (stops at 0xFFFF) grant count of requester stat_sel, cleared by reset.
REQ-030 SHALL, without FIFO_WR_ARB_STATS_EN, omit stat_sel, stat_count and all counter logic.

Verification
REQ-031 SHALL cover single requester: req[2]=1, data 0xA5A5A5A5 -> gnt[2], fifo_wr_en=1, fifo_data_in=0xA5A5A5A5 one cycle later, occupancy=1.
REQ-032 SHALL cover fairness: req=4'b1111 held for 8 grants after reset -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles.
REQ-033 SHALL cover credit exhaustion: FIFO_DEPTH=16, no reads, req[0] held -> exactly 16 writes, then blocked=1, occupancy=16, fifo_wr_en=0.
REQ-034 SHALL cover simultaneous events: occupancy=16 with one rd_fire and req[1]=1 -> occupancy 15 then grant, ending at 16; same-edge grant with rd_fire leaves occupancy unchanged.
REQ-035 SHALL cover mid-operation reset: reset=1 during a grant cycle with req=4'b0011 -> next cycle gnt=0, fifo_wr_en=0, occupancy=0, first post-reset grant to requester 0.
REQ-036 SHALL cover stats (macro defined): 3 grants to requester 1, stat_sel=1 -> stat_count=3.
